alu_trace_buf: RTL and testbench
================================

Name: alu_trace_buf

Overview:
Synthesizable, parametrised ALU transaction monitor for the MIPS datapath. It takes the same operands, control code and results the simulation-only ALU display monitor prints. Each qualified transaction is stored in a circular trace buffer. An arm/trigger/post-trigger state machine freezes the buffer around an event of interest. A registered read port lets the debug bench or a future debug unit dump the captured history.

Parameters:
DATA_W, 32, width of operands a/b and results rl/rh
CTRL_W, 4, width of ALU control code
DEPTH, 16, trace entries; power of 2, >= 2
PTR_W, $clog2(DEPTH), pointer/index width (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
smp_valid  in  1  ALU transaction present this cycle
smp_a  in  DATA_W  operand A
smp_b  in  DATA_W  operand B
smp_contr  in  CTRL_W  ALU control code
smp_equ  in  1  ALU equal flag
smp_rl  in  DATA_W  result low word
smp_rh  in  DATA_W  result high word
flt_mask  in  2**CTRL_W  per-opcode capture enable; bit k=1 captures contr==k
arm  in  1  pulse: clear buffer, enter ARMED
trig_op_en  in  1  enable opcode trigger
trig_contr  in  CTRL_W  opcode that triggers
trig_equ_en  in  1  enable trigger on smp_equ=1
post_len  in  PTR_W  entries captured after the trigger entry
rd_en  in  1  read request
rd_idx  in  PTR_W  logical index, 0 = oldest entry
rd_valid  out  1  read data valid (1 cycle after rd_en)
rd_miss  out  1  with rd_valid: rd_idx >= count, data zeroed
rd_a, rd_b, rd_rl, rd_rh  out  DATA_W each  read entry fields
rd_contr  out  CTRL_W  read entry control code
rd_equ  out  1  read entry equal flag
state  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3
frozen  out  1  state==FROZEN
count  out  PTR_W+1  valid entries, saturates at DEPTH
trig_pos  out  PTR_W  logical index of trigger entry; valid when frozen

Behaviour:
- Reset: state=IDLE, wr_ptr=0, count=0, post_cnt=0, trig_pos=0, rd_valid=0, rd_miss=0, all rd_* data 0. Buffer contents are don't-care.
- Capture qualifier: cap = smp_valid & flt_mask[smp_contr].
- Trigger: trg = cap & ((trig_op_en & smp_contr==trig_contr) | (trig_equ_en & smp_equ)).
- IDLE: no writes. arm -> ARMED.
- ARMED: on cap, write the entry at wr_ptr, advance wr_ptr mod DEPTH, increment count up to DEPTH.
  - On trg, the entry is also written and trig_ptr is latched to its physical slot.
  - post_len==0 -> FROZEN; otherwise post_cnt=post_len -> POST.
- POST: cap writes as in ARMED and decrements post_cnt. A write with post_cnt==1 -> FROZEN. Further triggers are ignored.
- FROZEN: no writes. Holds until arm.
- arm in any state: next cycle state=ARMED, wr_ptr=0, count=0. The sample offered in the arm cycle is dropped and arm takes priority over trg.
- Write-to-state latency: count and state reflect a capture on the cycle after it.
- Read mapping:
  - oldest = (count<DEPTH) ? 0 : wr_ptr
  - physical slot = (oldest + rd_idx) mod DEPTH
  - trig_pos = (trig_ptr - oldest) mod DEPTH, updated each cycle
- Reads are allowed in any state with 1-cycle latency. On the same slot, a read sees pre-write data (read-before-write).
- rd_valid is a 1-cycle pulse per rd_en; back-to-back reads give one result per cycle.
- A post_len larger than the remaining headroom overwrites the oldest entries and wraps. This is legal; the trigger entry is lost only if post_len >= DEPTH, which the port width prevents.
- rst mid-POST or mid-read: returns to IDLE; any pending rd_valid is cancelled.

Optional Feature:
- Macro: ALU_TRACE_PRINT_EN.
- Defined: each written entry is printed with $strobe as $time followed by state, wr_ptr, a, b, contr, equ, rl, rh in hex, plus a "TRIG" tag on the trigger entry. This replaces the free-running display monitor for this signal group. Simulation only.
- Undefined: no print code; RTL is identical otherwise.

Decomposition:
- Package alu_trace_pkg:
  - state encoding constants (IDLE, ARMED, POST, FROZEN)
  - entry field offsets and total entry width, CTRL_W+1+4*DATA_W
  - the default DATA_W and CTRL_W
- One sub-module alu_trace_ram: simple dual-port, DEPTH x entry width, one write port, registered read port.

Test Plan:
- Fill and wrap: rst, arm, flt_mask all 1s, no triggers, 20 samples with a=i. Then count=16; read idx 0..15 -> a = 4..19; read idx 15 then the next-cycle rd_valid shows a=19.
- Opcode trigger: DEPTH=16, post_len=3, trig_contr=4'h6, sample 6 of 10 has contr=6. FROZEN after sample 9; count=10, trig_pos=6; an 11th sample is not stored.
- Equal-flag trigger with post_len=0: first sample with equ=1 -> FROZEN the next cycle, trigger entry is the last entry, trig_pos=count-1.
- Filter: flt_mask = only contr=2, alternate contr 2/3 over 8 samples -> count=4, all rd_contr=2; a trigger on contr=3 is ignored.
- Arm vs trigger same cycle: arm plus a triggering sample -> state=ARMED, count=0. Read idx 0 -> rd_miss=1, data 0.
- Reset mid-POST: rst asserted in POST with rd_en high -> next cycle state=IDLE, count=0, rd_valid=0.

Source files
------------

// File: rtl/alu_trace_pkg.sv
// Shared definitions for the ALU transaction trace buffer:
// state encoding, default widths and entry field layout.
package alu_trace_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } trace_state_e;

  // Entry layout, LSB first: a, b, rl, rh, equ, contr
  localparam int OFF_A = 0;

  function automatic int off_b(int data_w);
    return data_w;
  endfunction

  function automatic int off_rl(int data_w);
    return 2 * data_w;
  endfunction

  function automatic int off_rh(int data_w);
    return 3 * data_w;
  endfunction

  function automatic int off_equ(int data_w);
    return 4 * data_w;
  endfunction

  function automatic int off_contr(int data_w);
    return 4 * data_w + 1;
  endfunction

  function automatic int entry_w(int data_w, int ctrl_w);
    return ctrl_w + 1 + 4 * data_w;
  endfunction

  localparam int DEF_ENTRY_W = entry_w(DEF_DATA_W, DEF_CTRL_W);

endpackage

// File: rtl/alu_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// Read-before-write on a shared address falls out of the non-blocking update.
module alu_trace_ram #(
  parameter int WIDTH = 133,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;

  // Registered read port, no reset on the data path
  always_ff @(posedge clk)
    if (re) rd_data <= mem[rd_addr];

endmodule

// File: rtl/alu_trace_buf.sv
// ALU transaction trace buffer with arm/trigger/post-trigger freeze and a
// 1-cycle read port addressed by logical index (0 = oldest entry).
// Optional macro ALU_TRACE_PRINT_EN adds a simulation-only log of stored entries.
module alu_trace_buf
  import alu_trace_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 smp_valid,
  input  logic [DATA_W-1:0]    smp_a,
  input  logic [DATA_W-1:0]    smp_b,
  input  logic [CTRL_W-1:0]    smp_contr,
  input  logic                 smp_equ,
  input  logic [DATA_W-1:0]    smp_rl,
  input  logic [DATA_W-1:0]    smp_rh,
  input  logic [2**CTRL_W-1:0] flt_mask,
  input  logic                 arm,
  input  logic                 trig_op_en,
  input  logic [CTRL_W-1:0]    trig_contr,
  input  logic                 trig_equ_en,
  input  logic [PTR_W-1:0]     post_len,
  input  logic                 rd_en,
  input  logic [PTR_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic                 rd_miss,
  output logic [DATA_W-1:0]    rd_a,
  output logic [DATA_W-1:0]    rd_b,
  output logic [DATA_W-1:0]    rd_rl,
  output logic [DATA_W-1:0]    rd_rh,
  output logic [CTRL_W-1:0]    rd_contr,
  output logic                 rd_equ,
  output logic [1:0]           state,
  output logic                 frozen,
  output logic [PTR_W:0]       count,
  output logic [PTR_W-1:0]     trig_pos
);

  localparam int ENT_W = entry_w(DATA_W, CTRL_W);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  trace_state_e     st, st_nx;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nx;
  logic [PTR_W-1:0] post_cnt, post_cnt_nx;
  logic [PTR_W-1:0] trig_ptr, trig_ptr_nx;
  logic [PTR_W:0]   count_nx;
  logic             cap, trg, we;
  logic [PTR_W-1:0] oldest, rd_addr;
  logic [ENT_W-1:0] wr_ent, rd_ent;
  logic             vld_p1, miss_p1;

  assign cap    = smp_valid & flt_mask[smp_contr];
  assign trg    = cap & ((trig_op_en & (smp_contr == trig_contr)) | (trig_equ_en & smp_equ));
  assign wr_ent = {smp_contr, smp_equ, smp_rh, smp_rl, smp_b, smp_a};

  // Until the buffer has wrapped, slot 0 holds the oldest entry
  assign oldest   = (count == FULL) ? wr_ptr : '0;
  assign rd_addr  = oldest + rd_idx;
  assign trig_pos = trig_ptr - oldest;
  assign state    = st;
  assign frozen   = (st == ST_FROZEN);

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
      trig_ptr <= '0;
    end else begin
      st       <= st_nx;
      wr_ptr   <= wr_ptr_nx;
      count    <= count_nx;
      post_cnt <= post_cnt_nx;
      trig_ptr <= trig_ptr_nx;
    end
  end

  // Next-state and write decision; arm overrides any capture or trigger
  always_comb begin
    st_nx       = st;
    wr_ptr_nx   = wr_ptr;
    count_nx    = count;
    post_cnt_nx = post_cnt;
    trig_ptr_nx = trig_ptr;
    we          = 1'b0;
    if (arm) begin
      st_nx       = ST_ARMED;
      wr_ptr_nx   = '0;
      count_nx    = '0;
      post_cnt_nx = '0;
    end else begin
      case (st)
        ST_ARMED, ST_POST: begin
          if (cap) begin
            we        = 1'b1;
            wr_ptr_nx = wr_ptr + PTR_W'(1);
            if (count != FULL) count_nx = count + (PTR_W+1)'(1);
            if (st == ST_ARMED) begin
              if (trg) begin
                trig_ptr_nx = wr_ptr;
                if (post_len == '0) begin
                  st_nx = ST_FROZEN;
                end else begin
                  post_cnt_nx = post_len;
                  st_nx       = ST_POST;
                end
              end
            end else begin
              post_cnt_nx = post_cnt - PTR_W'(1);
              if (post_cnt == PTR_W'(1)) st_nx = ST_FROZEN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  alu_trace_ram #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (wr_ent),
    .re      (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_ent)
  );

  // Read-port control: valid/miss travel one stage behind rd_en
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      miss_p1 <= 1'b0;
    end else begin
      vld_p1  <= rd_en;
      miss_p1 <= rd_en & ({1'b0, rd_idx} >= count);
    end
  end

  assign rd_valid = vld_p1;
  assign rd_miss  = miss_p1;

  // Read fields are zero unless a valid hit is being presented
  always_comb begin
    rd_a     = '0;
    rd_b     = '0;
    rd_rl    = '0;
    rd_rh    = '0;
    rd_contr = '0;
    rd_equ   = 1'b0;
    if (vld_p1 && !miss_p1) begin
      rd_a     = rd_ent[OFF_A +: DATA_W];
      rd_b     = rd_ent[off_b(DATA_W) +: DATA_W];
      rd_rl    = rd_ent[off_rl(DATA_W) +: DATA_W];
      rd_rh    = rd_ent[off_rh(DATA_W) +: DATA_W];
      rd_equ   = rd_ent[off_equ(DATA_W)];
      rd_contr = rd_ent[off_contr(DATA_W) +: CTRL_W];
    end
  end

`ifdef ALU_TRACE_PRINT_EN
  logic [1:0]       prt_st;
  logic [PTR_W-1:0] prt_ptr;
  logic [ENT_W-1:0] prt_ent;
  logic             prt_trg;

  // Snapshot pre-edge values so the end-of-step $strobe shows the write context
  always @(posedge clk) begin
    prt_st  <= st;
    prt_ptr <= wr_ptr;
    prt_ent <= wr_ent;
    prt_trg <= (st == ST_ARMED) && trg;
    if (we && !rst)
      $strobe("%0t %h %h %h %h %h %h %h %h%s", $time, prt_st, prt_ptr,
              prt_ent[OFF_A +: DATA_W], prt_ent[off_b(DATA_W) +: DATA_W],
              prt_ent[off_contr(DATA_W) +: CTRL_W], prt_ent[off_equ(DATA_W)],
              prt_ent[off_rl(DATA_W) +: DATA_W], prt_ent[off_rh(DATA_W) +: DATA_W],
              prt_trg ? " TRIG" : "");
  end
`endif

endmodule

// File: tb/tb_alu_trace_buf.sv
// Scoreboard bench for alu_trace_buf: a queue-based history model predicts
// read responses and state; a monitor pops expectations on every rd_valid.
module tb_alu_trace_buf;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, smp_valid, smp_equ, arm, trig_op_en, trig_equ_en, rd_en;
  logic [DATA_W-1:0] smp_a, smp_b, smp_rl, smp_rh;
  logic [CTRL_W-1:0] smp_contr, trig_contr;
  logic [15:0] flt_mask;
  logic [PTR_W-1:0] post_len, rd_idx;
  logic rd_valid, rd_miss, rd_equ, frozen;
  logic [DATA_W-1:0] rd_a, rd_b, rd_rl, rd_rh;
  logic [CTRL_W-1:0] rd_contr;
  logic [1:0] state;
  logic [PTR_W:0] count;
  logic [PTR_W-1:0] trig_pos;

  alu_trace_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .smp_valid(smp_valid), .smp_a(smp_a), .smp_b(smp_b),
    .smp_contr(smp_contr), .smp_equ(smp_equ), .smp_rl(smp_rl), .smp_rh(smp_rh),
    .flt_mask(flt_mask), .arm(arm), .trig_op_en(trig_op_en), .trig_contr(trig_contr),
    .trig_equ_en(trig_equ_en), .post_len(post_len), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_miss(rd_miss), .rd_a(rd_a), .rd_b(rd_b), .rd_rl(rd_rl),
    .rd_rh(rd_rh), .rd_contr(rd_contr), .rd_equ(rd_equ), .state(state),
    .frozen(frozen), .count(count), .trig_pos(trig_pos));

  typedef struct packed {
    logic [31:0] a, b, rl, rh;
    logic [3:0]  contr;
    logic        equ;
  } ent_t;
  typedef struct packed {
    logic miss;
    ent_t e;
  } rd_t;

  // Reference model: history as a plain queue, oldest at the front
  ent_t hist[$];
  int   m_state = 0;   // 0 idle, 1 armed, 2 post, 3 frozen
  int   m_post  = 0;
  int   m_trig  = 0;   // logical index of trigger entry
  rd_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Advance one clock, updating the model from the inputs in force this cycle
  task automatic tick();
    bit cap, trg;
    ent_t e;
    rd_t r;
    if (rd_en && !rst) begin
      r = '0;
      if (int'(rd_idx) < hist.size()) r.e = hist[rd_idx];
      else r.miss = 1'b1;
      exp_q.push_back(r);
    end
    cap = smp_valid && flt_mask[smp_contr];
    trg = cap && ((trig_op_en && smp_contr == trig_contr) || (trig_equ_en && smp_equ));
    if (rst) begin
      m_state = 0; hist.delete(); m_post = 0; m_trig = 0;
    end else if (arm) begin
      m_state = 1; hist.delete();
    end else if (cap && (m_state == 1 || m_state == 2)) begin
      e = '{a: smp_a, b: smp_b, rl: smp_rl, rh: smp_rh, contr: smp_contr, equ: smp_equ};
      hist.push_back(e);
      if (hist.size() > DEPTH) begin
        void'(hist.pop_front());
        m_trig--;
      end
      if (m_state == 1) begin
        if (trg) begin
          m_trig = hist.size() - 1;
          if (post_len == 0) m_state = 3;
          else begin m_post = post_len; m_state = 2; end
        end
      end else begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sample(logic [3:0] c, bit eq, logic [31:0] a);
    smp_valid = 1'b1; smp_contr = c; smp_equ = eq; smp_a = a;
    smp_b = $urandom; smp_rl = $urandom; smp_rh = $urandom;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic read_range(int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1; rd_idx = PTR_W'(i); tick();
    end
    rd_en = 1'b0;
    tick(); tick();
    chk("rd_drain", 64'(exp_q.size()), 0);
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_state"}, state, m_state);
    chk({tag, "_count"}, count, hist.size());
    if (m_state == 3) chk({tag, "_trig_pos"}, trig_pos, m_trig);
  endtask

  // Monitor: every rd_valid must match the oldest outstanding expectation
  rd_t mon_r;
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected actual=rd_valid required=no_read at %0t", $time);
      end else begin
        mon_r = exp_q.pop_front();
        chk("rd_miss", rd_miss, mon_r.miss);
        chk("rd_a", rd_a, mon_r.e.a);
        chk("rd_b", rd_b, mon_r.e.b);
        chk("rd_rl", rd_rl, mon_r.e.rl);
        chk("rd_rh", rd_rh, mon_r.e.rh);
        chk("rd_contr", rd_contr, mon_r.e.contr);
        chk("rd_equ", rd_equ, mon_r.e.equ);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; smp_valid = 0; smp_equ = 0; arm = 0; rd_en = 0; rd_idx = '0;
    smp_a = '0; smp_b = '0; smp_rl = '0; smp_rh = '0; smp_contr = '0;
    trig_op_en = 0; trig_equ_en = 0; trig_contr = '0; post_len = '0;
    flt_mask = 16'hFFFF;
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_miss", rd_miss, 0);
    chk("rst_rd_a", rd_a, 0);
    chk("rst_frozen", frozen, 0);
    chk("rst_trig_pos", trig_pos, 0);

    // Idle ignores samples
    sample(4'h1, 1'b0, 32'h55);
    chk("idle_count", count, 0);

    // Fill and wrap: 20 samples, a = i
    do_arm();
    chk("arm_state", state, 1);
    for (int i = 0; i < 20; i++) sample(4'($urandom_range(0, 15)), 1'b0, 32'(i));
    chk("fill_count", count, 16);
    chk_model("fill");
    read_range(16);
    rd_en = 1'b1; rd_idx = 4'd15; tick(); rd_en = 1'b0;
    chk("fill_rd_valid", rd_valid, 1);
    chk("fill_last_a", rd_a, 19);
    tick();
    chk("fill_pulse", rd_valid, 0);

    // Opcode trigger with post_len = 3
    trig_op_en = 1; trig_contr = 4'h6; post_len = 4'd3;
    do_arm();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk("op_post_state", state, 2);
      sample((i == 6) ? 4'h6 : 4'(i % 6), 1'b0, 32'(100 + i));
    end
    chk("op_state", state, 3);
    chk("op_frozen", frozen, 1);
    chk("op_count", count, 10);
    chk("op_trig_pos", trig_pos, 6);
    sample(4'h1, 1'b0, 32'hDEAD);
    chk("op_no_store", count, 10);
    read_range(12);

    // Equal-flag trigger with post_len = 0
    trig_op_en = 0; trig_equ_en = 1; post_len = '0;
    do_arm();
    for (int i = 0; i < 5; i++) sample(4'($urandom_range(0, 15)), 1'b0, $urandom);
    chk("equ_armed", state, 1);
    sample(4'h9, 1'b1, 32'hE0E0);
    chk("equ_state", state, 3);
    chk("equ_count", count, 6);
    chk("equ_trig_pos", trig_pos, 5);
    read_range(6);

    // Filter: only contr=2 captured; trigger on contr=3 never fires
    flt_mask = 16'h0004; trig_equ_en = 0; trig_op_en = 1; trig_contr = 4'h3; post_len = 4'd2;
    do_arm();
    for (int i = 0; i < 8; i++) sample((i % 2) ? 4'h3 : 4'h2, 1'b0, $urandom);
    chk("flt_count", count, 4);
    chk("flt_state", state, 1);
    read_range(4);

    // Arm and trigger in the same cycle
    flt_mask = 16'hFFFF; trig_contr = 4'h6;
    for (int i = 0; i < 3; i++) sample(4'h1, 1'b0, $urandom);
    arm = 1'b1; smp_valid = 1'b1; smp_contr = 4'h6; tick();
    arm = 1'b0; smp_valid = 1'b0;
    chk("armtrg_state", state, 1);
    chk("armtrg_count", count, 0);
    rd_en = 1'b1; rd_idx = '0; tick(); rd_en = 1'b0;
    chk("armtrg_miss", rd_miss, 1);
    chk("armtrg_data", rd_a, 0);
    tick();

    // Reset in POST with a read in flight
    post_len = 4'd5;
    sample(4'h6, 1'b0, 32'h1);
    sample(4'h2, 1'b0, 32'h2);
    chk("rstpost_state", state, 2);
    rst = 1'b1; rd_en = 1'b1; smp_valid = 1'b1; tick();
    rst = 1'b0; rd_en = 1'b0; smp_valid = 1'b0;
    chk("rstpost_idle", state, 0);
    chk("rstpost_count", count, 0);
    chk("rstpost_rd_valid", rd_valid, 0);
    chk("rstpost_rd_a", rd_a, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 40) == 0) begin
        flt_mask = 16'($urandom) | 16'h00FF;
        trig_op_en = 1'($urandom); trig_equ_en = 1'($urandom);
        trig_contr = 4'($urandom); post_len = 4'($urandom);
      end
      arm = ($urandom_range(0, 30) == 0);
      smp_valid = ($urandom_range(0, 2) != 0);
      smp_contr = 4'($urandom); smp_equ = ($urandom_range(0, 5) == 0);
      smp_a = $urandom; smp_b = $urandom; smp_rl = $urandom; smp_rh = $urandom;
      rd_en = ($urandom_range(0, 2) == 0); rd_idx = 4'($urandom);
      tick();
      chk_model("rnd");
    end
    arm = 0; smp_valid = 0; rd_en = 0;
    tick(); tick();
    chk("rnd_drain", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
